// File: rtl/cpx_accumulate.sv
// Coherent complex integrator: sums `length` accepted complex samples per frame and
// presents each full-precision frame sum through a one-entry output buffer.
module cpx_accumulate #(
    parameter int i_bits   = 24,
    parameter int q_bits   = 24,
    parameter int length   = 64,
    parameter int cnt_bits = $clog2(length) + 1,
    parameter int out_bits = ((i_bits > q_bits) ? i_bits : q_bits) + $clog2(length)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       m_axis_tvalid,
    input  logic signed [i_bits-1:0]   i,
    input  logic signed [q_bits-1:0]   q,
    output logic                       s_axis_tready,
    input  logic                       m_axis_tready,
    output logic                       s_axis_tvalid,
    output logic signed [out_bits-1:0] acc_i,
    output logic signed [out_bits-1:0] acc_q,
    output logic [cnt_bits-1:0]        sample_cnt
);

    localparam logic [cnt_bits-1:0] LAST_CNT = cnt_bits'(length - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t                 buf_state;
    buf_state_t                 buf_next;

    logic signed [out_bits-1:0] part_i;
    logic signed [out_bits-1:0] part_q;
    logic signed [out_bits-1:0] sum_i;
    logic signed [out_bits-1:0] sum_q;
    logic                       last;
    logic                       accept;
    logic                       frame_done;

    assign last          = (sample_cnt == LAST_CNT);
    assign s_axis_tvalid = (buf_state == FULL);

    // Only the closing sample of a frame can stall: it needs the output buffer to be free
    // (or draining on this very edge), while partial sums live in separate registers.
    assign s_axis_tready = ~(s_axis_tvalid & ~m_axis_tready & last);
    assign accept        = m_axis_tvalid & s_axis_tready & ~clear;
    assign frame_done    = accept & last;

    // Size casts of signed operands sign-extend, so the sum can never wrap.
    assign sum_i = part_i + out_bits'(i);
    assign sum_q = part_q + out_bits'(q);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_state <= EMPTY;
        end else begin
            buf_state <= buf_next;
        end
    end

    // NOTE: the default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        buf_next = buf_state;
        unique case (buf_state)
            EMPTY: if (frame_done) buf_next = FULL;
            FULL:  if (m_axis_tready && !frame_done) buf_next = EMPTY;
            default: buf_next = EMPTY;
        endcase
    end

    // NOTE: every datapath register is reset, since a reset must discard a pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_i     <= '0;
            part_q     <= '0;
            sample_cnt <= '0;
        end else if (clear || frame_done) begin
            part_i     <= '0;
            part_q     <= '0;
            sample_cnt <= '0;
        end else if (accept) begin
            part_i     <= sum_i;
            part_q     <= sum_q;
            sample_cnt <= sample_cnt + cnt_bits'(1);
        end
    end

    // The result registers only load on a frame boundary; clear leaves a held result alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i <= '0;
            acc_q <= '0;
        end else if (frame_done) begin
            acc_i <= sum_i;
            acc_q <= sum_q;
        end
    end

endmodule

// File: tb/tb_cpx_accumulate.sv
// Scoreboard bench for cpx_accumulate (length 4): a frame-sum model pushes expected
// results, a negedge monitor pops them on each output handshake.
module tb_cpx_accumulate;

    localparam int L  = 4;
    localparam int IB = 24;
    localparam int QB = 24;
    localparam int CB = $clog2(L) + 1;
    localparam int OB = 24 + $clog2(L);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clear = 1'b0;
    logic                 m_axis_tvalid = 1'b0;
    logic                 m_axis_tready = 1'b0;
    logic signed [IB-1:0] i = '0;
    logic signed [QB-1:0] q = '0;
    logic                 s_axis_tready;
    logic                 s_axis_tvalid;
    logic signed [OB-1:0] acc_i;
    logic signed [OB-1:0] acc_q;
    logic [CB-1:0]        sample_cnt;

    cpx_accumulate #(.i_bits(IB), .q_bits(QB), .length(L)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .m_axis_tvalid(m_axis_tvalid),
        .i            (i),
        .q            (q),
        .s_axis_tready(s_axis_tready),
        .m_axis_tready(m_axis_tready),
        .s_axis_tvalid(s_axis_tvalid),
        .acc_i        (acc_i),
        .acc_q        (acc_q),
        .sample_cnt   (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint re;
        longint im;
    } cpx_t;

    cpx_t   sb[$];
    longint si = 0;
    longint sq = 0;
    int     m_cnt = 0;
    bit     m_full = 1'b0;
    bit     m_acc = 1'b0;
    int     pushed = 0;
    int     total = 0;
    int     bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected accept", name);
    endtask

    // Frame-level model evaluated on each rising edge with the inputs held over that cycle.
    task automatic model_edge();
        bit   last;
        bit   rdy;
        cpx_t r;
        last  = (m_cnt == L - 1);
        rdy   = !(m_full && !m_axis_tready && last);
        m_acc = m_axis_tvalid && rdy && !clear;
        if (m_full && m_axis_tready) m_full = 1'b0;
        if (clear) begin
            si = 0; sq = 0; m_cnt = 0;
        end else if (m_acc) begin
            si += longint'(i);
            sq += longint'(q);
            m_cnt++;
            if (m_cnt == L) begin
                r.re = si; r.im = sq;
                sb.push_back(r);
                pushed++;
                m_full = 1'b1;
                si = 0; sq = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic model_reset();
        sb.delete();
        si = 0; sq = 0; m_cnt = 0; m_full = 1'b0; m_acc = 1'b0;
    endtask

    task automatic step(input bit v, input int iv, input int qv, input bit mr, input bit clr);
        m_axis_tvalid = v;
        i             = IB'(iv);
        q             = QB'(qv);
        m_axis_tready = mr;
        clear         = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input int iv, input int qv, input bit mr, input bit rand_mr);
        int n;
        n = 0;
        do begin
            step(1'b1, iv, qv, rand_mr ? bit'($urandom_range(0, 1)) : mr, 1'b0);
            n++;
        end while (!m_acc && n < 50);
        if (!m_acc) fail("send_timeout");
        m_axis_tvalid = 1'b0;
    endtask

    function automatic int rnd24();
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel == 0) return -8388608;
        if (sel == 1) return 8388607;
        return int'($urandom_range(0, 32'h00FF_FFFF)) - 8388608;
    endfunction

    // Monitor: checks handshake outputs each cycle and pops a result on every output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            check("tvalid", longint'(s_axis_tvalid), longint'(sb.size() > 0));
            check("tready", longint'(s_axis_tready),
                  longint'(!(sb.size() > 0 && !m_axis_tready && m_cnt == L - 1)));
            check("sample_cnt", longint'(sample_cnt), longint'(m_cnt));
            if (s_axis_tvalid && m_axis_tready && sb.size() > 0) begin
                cpx_t e;
                e = sb.pop_front();
                check("result_i", longint'(acc_i), e.re);
                check("result_q", longint'(acc_q), e.im);
            end
        end
    end

    initial begin
        // Reset state.
        #11;
        check("rst_valid", longint'(s_axis_tvalid), 0);
        check("rst_acc_i", longint'(acc_i), 0);
        check("rst_acc_q", longint'(acc_q), 0);
        check("rst_cnt", longint'(sample_cnt), 0);
        #1 rst_n = 1'b1;
        check("rst_ready", longint'(s_axis_tready), 1);

        // Back-to-back frame with downstream always ready: one-cycle result.
        for (int k = 1; k <= 4; k++) send(k, -k, 1'b1, 1'b0);
        check("basic_valid", longint'(s_axis_tvalid), 1);
        check("basic_i", longint'(acc_i), 10);
        check("basic_q", longint'(acc_q), -10);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        check("basic_valid_drop", longint'(s_axis_tvalid), 0);

        // Extreme operands: no wrap in the widened result.
        for (int k = 0; k < 4; k++) send(-8388608, 8388607, 1'b1, 1'b0);
        check("ext_i", longint'(acc_i), -33554432);
        check("ext_q", longint'(acc_q), 33554428);
        step(1'b0, 0, 0, 1'b1, 1'b0);

        // Backpressure: first result held, final sample of frame 2 stalls.
        for (int k = 0; k < 7; k++) send(1, 1, 1'b0, 1'b0);
        check("bp_ready", longint'(s_axis_tready), 0);
        check("bp_cnt", longint'(sample_cnt), 3);
        check("bp_hold_i", longint'(acc_i), 4);
        step(1'b1, 1, 1, 1'b0, 1'b0);
        step(1'b1, 1, 1, 1'b0, 1'b0);
        check("bp_stalled_cnt", longint'(sample_cnt), 3);
        send(1, 1, 1'b1, 1'b0);
        check("bp_reload_valid", longint'(s_axis_tvalid), 1);
        check("bp_reload_q", longint'(acc_q), 4);
        step(1'b0, 0, 0, 1'b1, 1'b0);

        // Clear mid-frame, then clear with a held result.
        send(9, 9, 1'b1, 1'b0);
        send(9, 9, 1'b1, 1'b0);
        check("clr_cnt_before", longint'(sample_cnt), 2);
        step(1'b1, 7, 7, 1'b1, 1'b1);
        check("clr_cnt_after", longint'(sample_cnt), 0);
        for (int k = 0; k < 4; k++) send(5, 0, 1'b0, 1'b0);
        check("clr_sum_i", longint'(acc_i), 20);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        check("clr_hold_valid", longint'(s_axis_tvalid), 1);
        check("clr_hold_i", longint'(acc_i), 20);
        check("clr_hold_q", longint'(acc_q), 0);
        step(1'b0, 0, 0, 1'b1, 1'b0);

        // Asynchronous reset mid-frame with a result pending.
        for (int k = 0; k < 4; k++) send(2, 3, 1'b0, 1'b0);
        send(1, 1, 1'b0, 1'b0);
        send(1, 1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", longint'(s_axis_tvalid), 0);
        check("arst_acc_i", longint'(acc_i), 0);
        check("arst_acc_q", longint'(acc_q), 0);
        check("arst_cnt", longint'(sample_cnt), 0);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) send(3, -1, 1'b1, 1'b0);
        check("arst_next_i", longint'(acc_i), 12);
        check("arst_next_q", longint'(acc_q), -4);
        step(1'b0, 0, 0, 1'b1, 1'b0);

        // Random gaps, random backpressure, rare clears over 1000 frames.
        pushed = 0;
        while (pushed < 1000) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b0, 0, 0, bit'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
            else
                send(rnd24(), rnd24(), 1'b0, 1'b1);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b1, 1'b0);
        check("leftover", longint'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
